fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/mycpu_pkg.sv | 37 +++
 rtl/fetch_utlb.sv | 69 ++++++
 rtl/fetch_pc_gen.sv | 172 +++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU constants: exception codes, kseg decode, reset vector and fetch types.
// Also holds the micro-TLB entry layout used by the fetch PC generator.
package mycpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;

    localparam logic [4:0] EXC_ADEL = 5'h4;
    localparam logic [4:0] EXC_TLBL = 5'h2;

    // kseg0/kseg1 share the top two bits 2'b10; kseg1 alone is uncached
    localparam logic [1:0] KSEG01_TOP = 2'b10;
    localparam logic [2:0] KSEG1_TOP  = 3'b101;

    typedef enum logic [1:0] {
        FS_RUN  = 2'd0,
        FS_WALK = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic        found;
        logic        v;
        logic [19:0] pfn;
    } utlb_entry_t;

    function automatic logic addr_mapped(input logic [31:0] addr);
        return addr[31:30] != KSEG01_TOP;
    endfunction

    function automatic logic addr_uncached(input logic [31:0] addr);
        return addr[31:29] == KSEG1_TOP;
    endfunction

endpackage

// File: rtl/fetch_utlb.sv
// Fully associative instruction micro-TLB with round-robin replacement.
// Entries keep the main-TLB found/v flags so misses and invalid pages can raise exceptions.
module fetch_utlb
    import mycpu_pkg::*;
#(
    parameter int UTLB_ENTRIES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [18:0] vpn2,
    input  logic        odd,
    input  logic [7:0]  asid,
    output logic        hit,
    output logic        found,
    output logic        v,
    output logic [19:0] pfn,
    input  logic        install,
    input  utlb_entry_t install_entry
);

    localparam int PTR_W = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1;

    logic [UTLB_ENTRIES-1:0] valid;
    utlb_entry_t             entry [UTLB_ENTRIES];
    logic [PTR_W-1:0]        victim;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < UTLB_ENTRIES; i++) begin
                if (install && victim == PTR_W'(i)) valid[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            victim <= '0;
        end else if (install && !flush) begin
            victim <= (victim == PTR_W'(UTLB_ENTRIES - 1)) ? '0 : victim + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < UTLB_ENTRIES; i++) begin
            if (install && victim == PTR_W'(i)) entry[i] <= install_entry;
        end
    end

    // First matching entry wins; entries never duplicate a page in practice
    always_comb begin
        hit   = 1'b0;
        found = 1'b0;
        v     = 1'b0;
        pfn   = '0;
        for (int i = 0; i < UTLB_ENTRIES; i++) begin
            if (!hit && valid[i] && entry[i].vpn2 == vpn2 &&
                entry[i].odd == odd && entry[i].asid == asid) begin
                hit   = 1'b1;
                found = entry[i].found;
                v     = entry[i].v;
                pfn   = entry[i].pfn;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: picks the next fetch group, translates it through the micro-TLB,
// issues the I-cache request and reports fetch exceptions to the IF stage.
module fetch_pc_gen
    import mycpu_pkg::*;
#(
    parameter int          FETCH_WIDTH  = 2,
    parameter int          UTLB_ENTRIES = 2,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fs_allowin,
    input  logic                         br_valid,
    input  logic [31:0]                  br_target,
    input  logic                         reflush,
    input  logic [31:0]                  reflush_pc,
    output logic                         to_fs_valid,
    output logic [31:0]                  to_fs_pc,
    output logic [$clog2(FETCH_WIDTH):0] to_fs_cnt,
    output logic                         to_fs_exc,
    output logic [4:0]                   to_fs_exc_code,
    output logic                         to_fs_tlb_refill,
    output logic                         ic_valid,
    output logic                         ic_uncache,
    output logic [31:0]                  ic_addr,
    input  logic                         ic_addr_ok,
    output logic [18:0]                  tlb_vpn2,
    output logic                         tlb_odd,
    output logic [7:0]                   tlb_asid,
    input  logic                         tlb_found,
    input  logic                         tlb_v,
    input  logic [19:0]                  tlb_pfn,
    input  logic                         tlb_write,
    input  logic [7:0]                   cp0_asid
);

    localparam int          GROUP_BYTES = FETCH_WIDTH * 4;
    localparam int          OFF_W       = $clog2(GROUP_BYTES);
    localparam int          CNT_W       = $clog2(FETCH_WIDTH) + 1;
    localparam logic [31:0] GROUP_MASK  = ~(32'(GROUP_BYTES) - 32'd1);

    fetch_state_e state, state_n;

    logic [31:0] pc, pend_flush_pc, pend_br_pc;
    logic        pend_flush, pend_br;

    logic [31:0]      nextpc, seq_pc;
    logic [CNT_W-1:0] word_off, group_cnt;
    logic             mapped, utlb_hit, utlb_found, utlb_v;
    logic [19:0]      utlb_pfn;
    logic             exc_adel, exc_tlb, exc_any;
    logic             run, walk, issue, walk_install;
    utlb_entry_t      walk_entry;

    always_comb begin
        if (reflush)         nextpc = reflush_pc;
        else if (pend_flush) nextpc = pend_flush_pc;
        else if (br_valid)   nextpc = br_target;
        else if (pend_br)    nextpc = pend_br_pc;
        else                 nextpc = pc;
    end

    generate
        if (FETCH_WIDTH == 1) begin : g_single
            assign word_off = '0;
        end else begin : g_multi
            assign word_off = CNT_W'(nextpc[OFF_W-1:2]);
        end
    endgenerate

    // Groups stop at the aligned group boundary, so the next group starts there
    assign group_cnt = CNT_W'(FETCH_WIDTH) - word_off;
    assign seq_pc    = (nextpc & GROUP_MASK) + 32'(GROUP_BYTES);

    assign mapped = addr_mapped(nextpc);

    assign walk_entry = '{vpn2: nextpc[31:13], odd: nextpc[12], asid: cp0_asid,
                          found: tlb_found, v: tlb_v, pfn: tlb_pfn};

    fetch_utlb #(
        .UTLB_ENTRIES (UTLB_ENTRIES)
    ) u_utlb (
        .clk           (clk),
        .reset         (reset),
        .flush         (tlb_write),
        .vpn2          (nextpc[31:13]),
        .odd           (nextpc[12]),
        .asid          (cp0_asid),
        .hit           (utlb_hit),
        .found         (utlb_found),
        .v             (utlb_v),
        .pfn           (utlb_pfn),
        .install       (walk_install),
        .install_entry (walk_entry)
    );

    assign exc_adel = nextpc[1:0] != 2'b00;
    assign exc_tlb  = mapped && utlb_hit && (!utlb_found || !utlb_v);
    assign exc_any  = exc_adel || exc_tlb;

    assign run   = !reset && state == FS_RUN;
    assign walk  = !reset && state == FS_WALK;

    assign ic_valid = run && fs_allowin && !exc_any && (utlb_hit || !mapped);
    assign issue    = (ic_valid && ic_addr_ok) || (run && fs_allowin && exc_any);

    assign ic_uncache = !reset && addr_uncached(nextpc);
    assign ic_addr    = reset  ? 32'd0 :
                        mapped ? {utlb_pfn, nextpc[11:0]} : {3'b000, nextpc[28:0]};

    assign to_fs_valid      = issue;
    assign to_fs_pc         = reset ? RESET_PC : nextpc;
    assign to_fs_cnt        = reset ? '0 : group_cnt;
    assign to_fs_exc        = issue && exc_any;
    assign to_fs_exc_code   = !(issue && exc_any) ? 5'd0 : (exc_adel ? EXC_ADEL : EXC_TLBL);
    assign to_fs_tlb_refill = issue && !exc_adel && exc_tlb && !utlb_found;

    assign tlb_vpn2 = walk ? nextpc[31:13] : '0;
    assign tlb_odd  = walk && nextpc[12];
    assign tlb_asid = walk ? cp0_asid : '0;

    always_comb begin
        state_n      = state;
        walk_install = 1'b0;
        case (state)
            FS_RUN: begin
                if (fs_allowin && exc_any)                     state_n = FS_HALT;
                else if (fs_allowin && mapped && !utlb_hit)    state_n = FS_WALK;
            end
            FS_WALK: begin
                // A TLB write mid-walk may have changed the entry; search again
                if (reflush) begin
                    state_n = FS_RUN;
                end else if (!tlb_write) begin
                    walk_install = !reset;
                    state_n      = FS_RUN;
                end
            end
            FS_HALT: begin
                if (reflush) state_n = FS_RUN;
            end
            default: state_n = FS_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FS_RUN;
            pc         <= RESET_PC;
            pend_flush <= 1'b0;
            pend_br    <= 1'b0;
        end else begin
            state <= state_n;
            if (issue) pc <= seq_pc;
            if (reflush) begin
                pend_flush <= !issue;
                pend_br    <= 1'b0;
            end else if (issue) begin
                pend_flush <= 1'b0;
                pend_br    <= 1'b0;
            end else if (br_valid && !pend_flush) begin
                pend_br <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reflush) pend_flush_pc <= reflush_pc;
        if (br_valid && !reflush && !pend_flush) pend_br_pc <= br_target;
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed testbench for fetch_pc_gen: a FETCH_WIDTH=2 instance checked throughout,
// plus a FETCH_WIDTH=4 instance sharing the same inputs for group-boundary checks.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fs_allowin = 1'b1;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        reflush = 1'b0;
    logic [31:0] reflush_pc = '0;
    logic        ic_addr_ok = 1'b1;
    logic        tlb_found = 1'b0;
    logic        tlb_v = 1'b0;
    logic [19:0] tlb_pfn = '0;
    logic        tlb_write = 1'b0;
    logic [7:0]  cp0_asid = '0;

    logic        to_fs_valid, to_fs_exc, to_fs_tlb_refill, ic_valid, ic_uncache, tlb_odd;
    logic [31:0] to_fs_pc, ic_addr;
    logic [1:0]  to_fs_cnt;
    logic [4:0]  to_fs_exc_code;
    logic [18:0] tlb_vpn2;
    logic [7:0]  tlb_asid;

    logic        to_fs_valid4, to_fs_exc4, to_fs_tlb_refill4, ic_valid4, ic_uncache4, tlb_odd4;
    logic [31:0] to_fs_pc4, ic_addr4;
    logic [2:0]  to_fs_cnt4;
    logic [4:0]  to_fs_exc_code4;
    logic [18:0] tlb_vpn24;
    logic [7:0]  tlb_asid4;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(.FETCH_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin),
        .br_valid(br_valid), .br_target(br_target),
        .reflush(reflush), .reflush_pc(reflush_pc),
        .to_fs_valid(to_fs_valid), .to_fs_pc(to_fs_pc), .to_fs_cnt(to_fs_cnt),
        .to_fs_exc(to_fs_exc), .to_fs_exc_code(to_fs_exc_code), .to_fs_tlb_refill(to_fs_tlb_refill),
        .ic_valid(ic_valid), .ic_uncache(ic_uncache), .ic_addr(ic_addr), .ic_addr_ok(ic_addr_ok),
        .tlb_vpn2(tlb_vpn2), .tlb_odd(tlb_odd), .tlb_asid(tlb_asid),
        .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_pfn(tlb_pfn),
        .tlb_write(tlb_write), .cp0_asid(cp0_asid)
    );

    fetch_pc_gen #(.FETCH_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin),
        .br_valid(br_valid), .br_target(br_target),
        .reflush(reflush), .reflush_pc(reflush_pc),
        .to_fs_valid(to_fs_valid4), .to_fs_pc(to_fs_pc4), .to_fs_cnt(to_fs_cnt4),
        .to_fs_exc(to_fs_exc4), .to_fs_exc_code(to_fs_exc_code4), .to_fs_tlb_refill(to_fs_tlb_refill4),
        .ic_valid(ic_valid4), .ic_uncache(ic_uncache4), .ic_addr(ic_addr4), .ic_addr_ok(ic_addr_ok),
        .tlb_vpn2(tlb_vpn24), .tlb_odd(tlb_odd4), .tlb_asid(tlb_asid4),
        .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_pfn(tlb_pfn),
        .tlb_write(tlb_write), .cp0_asid(cp0_asid)
    );

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        total++; if (to_fs_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", to_fs_valid); else passed++;
        total++; if (ic_valid !== 1'b0) $display("FAIL reset_ic_valid got %b want 0", ic_valid); else passed++;
        total++; if (to_fs_pc !== 32'hbfc00000) $display("FAIL reset_pc got %h want bfc00000", to_fs_pc); else passed++;
        total++; if (to_fs_cnt !== 2'd0) $display("FAIL reset_cnt got %0d want 0", to_fs_cnt); else passed++;
        total++; if (ic_addr !== 32'h0) $display("FAIL reset_ic_addr got %h want 0", ic_addr); else passed++;
        total++; if (ic_uncache !== 1'b0) $display("FAIL reset_uncache got %b want 0", ic_uncache); else passed++;
        total++; if (to_fs_pc4 !== 32'hbfc00000) $display("FAIL reset_pc4 got %h want bfc00000", to_fs_pc4); else passed++;
    endtask

    task automatic test_sequential();
        @(negedge clk); reset = 1'b0; #1;
        total++; if (to_fs_valid !== 1'b1) $display("FAIL seq0_valid got %b want 1", to_fs_valid); else passed++;
        total++; if (to_fs_pc !== 32'hbfc00000) $display("FAIL seq0_pc got %h want bfc00000", to_fs_pc); else passed++;
        total++; if (to_fs_cnt !== 2'd2) $display("FAIL seq0_cnt got %0d want 2", to_fs_cnt); else passed++;
        total++; if (ic_addr !== 32'h1fc00000) $display("FAIL seq0_ic_addr got %h want 1fc00000", ic_addr); else passed++;
        total++; if (ic_uncache !== 1'b1) $display("FAIL seq0_uncache got %b want 1", ic_uncache); else passed++;
        @(negedge clk); #1;
        total++; if (to_fs_pc !== 32'hbfc00008) $display("FAIL seq1_pc got %h want bfc00008", to_fs_pc); else passed++;
        total++; if (to_fs_cnt !== 2'd2) $display("FAIL seq1_cnt got %0d want 2", to_fs_cnt); else passed++;
        @(negedge clk); #1;
        total++; if (to_fs_pc !== 32'hbfc00010) $display("FAIL seq2_pc got %h want bfc00010", to_fs_pc); else passed++;
        total++; if (to_fs_valid !== 1'b1) $display("FAIL seq2_valid got %b want 1", to_fs_valid); else passed++;
    endtask

    task automatic test_branch_boundary();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; br_valid = 1'b1; br_target = 32'h8000000c; #1;
        total++; if (to_fs_pc4 !== 32'h8000000c) $display("FAIL br4_pc got %h want 8000000c", to_fs_pc4); else passed++;
        total++; if (to_fs_cnt4 !== 3'd1) $display("FAIL br4_cnt got %0d want 1", to_fs_cnt4); else passed++;
        total++; if (ic_addr4 !== 32'h0000000c) $display("FAIL br4_ic_addr got %h want 0000000c", ic_addr4); else passed++;
        total++; if (ic_uncache4 !== 1'b0) $display("FAIL br4_uncache got %b want 0", ic_uncache4); else passed++;
        total++; if (to_fs_cnt !== 2'd1) $display("FAIL br2_cnt got %0d want 1", to_fs_cnt); else passed++;
        @(negedge clk); br_valid = 1'b0; #1;
        total++; if (to_fs_pc4 !== 32'h80000010) $display("FAIL br4_next_pc got %h want 80000010", to_fs_pc4); else passed++;
        total++; if (to_fs_cnt4 !== 3'd4) $display("FAIL br4_next_cnt got %0d want 4", to_fs_cnt4); else passed++;
        total++; if (to_fs_pc !== 32'h80000010) $display("FAIL br2_next_pc got %h want 80000010", to_fs_pc); else passed++;
        total++; if (to_fs_cnt !== 2'd2) $display("FAIL br2_next_cnt got %0d want 2", to_fs_cnt); else passed++;
    endtask

    task automatic test_stall_branch();
        @(negedge clk); ic_addr_ok = 1'b0; #1;
        total++; if (ic_valid !== 1'b1) $display("FAIL stall_ic_valid got %b want 1", ic_valid); else passed++;
        total++; if (to_fs_valid !== 1'b0) $display("FAIL stall_valid got %b want 0", to_fs_valid); else passed++;
        total++; if (ic_addr !== 32'h00000018) $display("FAIL stall_ic_addr got %h want 00000018", ic_addr); else passed++;
        @(negedge clk); br_valid = 1'b1; br_target = 32'h80000100; #1;
        total++; if (ic_addr !== 32'h00000100) $display("FAIL stall_br_addr got %h want 00000100", ic_addr); else passed++;
        @(negedge clk); br_valid = 1'b0; #1;
        total++; if (ic_addr !== 32'h00000100) $display("FAIL stall_hold1 got %h want 00000100", ic_addr); else passed++;
        total++; if (to_fs_valid !== 1'b0) $display("FAIL stall_hold_valid got %b want 0", to_fs_valid); else passed++;
        @(negedge clk); #1;
        total++; if (ic_addr !== 32'h00000100) $display("FAIL stall_hold2 got %h want 00000100", ic_addr); else passed++;
        @(negedge clk); ic_addr_ok = 1'b1; #1;
        total++; if (to_fs_valid !== 1'b1 || to_fs_pc !== 32'h80000100)
            $display("FAIL stall_issue got %b/%h want 1/80000100", to_fs_valid, to_fs_pc); else passed++;
        @(negedge clk); #1;
        total++; if (to_fs_pc !== 32'h80000108) $display("FAIL stall_after got %h want 80000108", to_fs_pc); else passed++;
    endtask

    task automatic test_flush_and_branch();
        @(negedge clk); ic_addr_ok = 1'b0;
        reflush = 1'b1; reflush_pc = 32'hbfc00100; br_valid = 1'b1; br_target = 32'h80000200; #1;
        total++; if (ic_addr !== 32'h1fc00100) $display("FAIL fb_ic_addr got %h want 1fc00100", ic_addr); else passed++;
        total++; if (to_fs_valid !== 1'b0) $display("FAIL fb_valid got %b want 0", to_fs_valid); else passed++;
        @(negedge clk); reflush = 1'b0; br_valid = 1'b0; ic_addr_ok = 1'b1; #1;
        total++; if (to_fs_valid !== 1'b1 || to_fs_pc !== 32'hbfc00100)
            $display("FAIL fb_issue got %b/%h want 1/bfc00100", to_fs_valid, to_fs_pc); else passed++;
        @(negedge clk); #1;
        total++; if (to_fs_pc !== 32'hbfc00108) $display("FAIL fb_after got %h want bfc00108", to_fs_pc); else passed++;
    endtask

    task automatic test_mapped_walk();
        tlb_found = 1'b1; tlb_v = 1'b1; tlb_pfn = 20'h00123;
        @(negedge clk); reflush = 1'b1; reflush_pc = 32'h00400000; #1;
        total++; if (ic_valid !== 1'b0 || to_fs_valid !== 1'b0)
            $display("FAIL mw_miss got %b/%b want 0/0", ic_valid, to_fs_valid); else passed++;
        @(negedge clk); reflush = 1'b0; #1;
        total++; if (tlb_vpn2 !== 19'h00200) $display("FAIL mw_walk_vpn2 got %h want 00200", tlb_vpn2); else passed++;
        total++; if (ic_valid !== 1'b0) $display("FAIL mw_walk_ic_valid got %b want 0", ic_valid); else passed++;
        @(negedge clk); #1;
        total++; if (ic_addr !== 32'h00123000) $display("FAIL mw_ic_addr got %h want 00123000", ic_addr); else passed++;
        total++; if (to_fs_valid !== 1'b1 || to_fs_pc !== 32'h00400000)
            $display("FAIL mw_issue got %b/%h want 1/00400000", to_fs_valid, to_fs_pc); else passed++;
        total++; if (tlb_vpn2 !== 19'h0) $display("FAIL mw_run_vpn2 got %h want 0", tlb_vpn2); else passed++;
        @(negedge clk); #1;
        total++; if (ic_addr !== 32'h00123008) $display("FAIL mw_hit2 got %h want 00123008", ic_addr); else passed++;
        @(negedge clk); tlb_write = 1'b1; fs_allowin = 1'b0; #1;
        total++; if (to_fs_valid !== 1'b0) $display("FAIL mw_noallow got %b want 0", to_fs_valid); else passed++;
        @(negedge clk); tlb_write = 1'b0; fs_allowin = 1'b1; #1;
        total++; if (ic_valid !== 1'b0) $display("FAIL mw_flushed got %b want 0", ic_valid); else passed++;
        @(negedge clk); tlb_write = 1'b1; #1;
        total++; if (tlb_vpn2 !== 19'h00200) $display("FAIL mw_rewalk got %h want 00200", tlb_vpn2); else passed++;
        @(negedge clk); tlb_write = 1'b0; #1;
        total++; if (tlb_vpn2 !== 19'h00200 || ic_valid !== 1'b0)
            $display("FAIL mw_walk_retry got %h/%b want 00200/0", tlb_vpn2, ic_valid); else passed++;
        @(negedge clk); #1;
        total++; if (ic_addr !== 32'h00123010 || to_fs_pc !== 32'h00400010)
            $display("FAIL mw_refetch got %h/%h want 00123010/00400010", ic_addr, to_fs_pc); else passed++;
    endtask

    task automatic test_exceptions();
        @(negedge clk); reflush = 1'b1; reflush_pc = 32'h00400002; #1;
        total++; if (to_fs_valid !== 1'b1 || to_fs_exc !== 1'b1)
            $display("FAIL adel_issue got %b/%b want 1/1", to_fs_valid, to_fs_exc); else passed++;
        total++; if (to_fs_exc_code !== 5'h4) $display("FAIL adel_code got %h want 04", to_fs_exc_code); else passed++;
        total++; if (ic_valid !== 1'b0) $display("FAIL adel_ic_valid got %b want 0", ic_valid); else passed++;
        @(negedge clk); reflush = 1'b0; #1;
        total++; if (to_fs_valid !== 1'b0 || ic_valid !== 1'b0)
            $display("FAIL halt_idle got %b/%b want 0/0", to_fs_valid, ic_valid); else passed++;
        tlb_found = 1'b0;
        @(negedge clk); reflush = 1'b1; reflush_pc = 32'h00402000; #1;
        total++; if (to_fs_valid !== 1'b0) $display("FAIL refill_halt got %b want 0", to_fs_valid); else passed++;
        @(negedge clk); reflush = 1'b0; #1;
        @(negedge clk); #1;
        total++; if (tlb_vpn2 !== 19'h00201) $display("FAIL refill_walk got %h want 00201", tlb_vpn2); else passed++;
        @(negedge clk); #1;
        total++; if (to_fs_valid !== 1'b1 || to_fs_exc_code !== 5'h2 || to_fs_tlb_refill !== 1'b1)
            $display("FAIL refill_exc got %b/%h/%b want 1/02/1", to_fs_valid, to_fs_exc_code, to_fs_tlb_refill); else passed++;
        tlb_found = 1'b1; tlb_v = 1'b0;
        @(negedge clk); reflush = 1'b1; reflush_pc = 32'h00404000; #1;
        @(negedge clk); reflush = 1'b0; #1;
        @(negedge clk); #1;
        total++; if (tlb_vpn2 !== 19'h00202) $display("FAIL inv_walk got %h want 00202", tlb_vpn2); else passed++;
        @(negedge clk); #1;
        total++; if (to_fs_valid !== 1'b1 || to_fs_exc_code !== 5'h2 || to_fs_tlb_refill !== 1'b0)
            $display("FAIL inv_exc got %b/%h/%b want 1/02/0", to_fs_valid, to_fs_exc_code, to_fs_tlb_refill); else passed++;
        @(negedge clk); reflush = 1'b1; reflush_pc = 32'hbfc00380; #1;
        total++; if (to_fs_valid !== 1'b0) $display("FAIL resume_halt got %b want 0", to_fs_valid); else passed++;
        @(negedge clk); reflush = 1'b0; #1;
        total++; if (to_fs_valid !== 1'b1 || to_fs_pc !== 32'hbfc00380 || to_fs_exc !== 1'b0)
            $display("FAIL resume_issue got %b/%h/%b want 1/bfc00380/0", to_fs_valid, to_fs_pc, to_fs_exc); else passed++;
        total++; if (ic_addr !== 32'h1fc00380) $display("FAIL resume_ic_addr got %h want 1fc00380", ic_addr); else passed++;
        @(negedge clk); #1;
        total++; if (to_fs_pc !== 32'hbfc00388) $display("FAIL resume_next got %h want bfc00388", to_fs_pc); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_boundary();
        test_stall_branch();
        test_flush_and_branch();
        test_mapped_walk();
        test_exceptions();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
